// File: rtl/gpio_in_debounce.sv
// GPIO pad input conditioning: per-bit synchroniser chain followed by a
// stability-counter debouncer, producing a clean level plus rise/fall pulses.
module gpio_in_debounce #(
  parameter int unsigned          GpioCount      = 16,
  parameter int unsigned          SyncStages     = 2,
  parameter int unsigned          DebounceCycles = 500000,
  parameter logic [GpioCount-1:0] ResetValue     = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [GpioCount-1:0] gpio_raw_i,
  input  logic                 bypass_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic                 change_o
);

  localparam int unsigned    CntW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  if (SyncStages < 2) begin : g_bad_sync_stages
    $fatal(1, "gpio_in_debounce: SyncStages must be at least 2");
  end
  if (DebounceCycles < 1) begin : g_bad_debounce_cycles
    $fatal(1, "gpio_in_debounce: DebounceCycles must be at least 1");
  end

  logic [GpioCount-1:0] sync_q [SyncStages];
  logic [GpioCount-1:0] sync;
  logic [GpioCount-1:0] stable_q;
  logic [GpioCount-1:0] stable_d;
  logic [CntW-1:0]      cnt_q [GpioCount];
  logic [CntW-1:0]      cnt_d [GpioCount];
  logic [GpioCount-1:0] rise_q;
  logic [GpioCount-1:0] fall_q;
  logic                 change_q;

  // Plain flop chain: no logic between stages so each stage can resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= ResetValue;
      end
    end else begin
      sync_q[0] <= gpio_raw_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SyncStages-1];

  // A bit is accepted only after DebounceCycles consecutive mismatching
  // samples; any match (or bypass) drops the partial count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < GpioCount; i++) begin
      cnt_d[i] = '0;
      if (bypass_i) begin
        stable_d[i] = sync[i];
      end else if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= ResetValue;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < GpioCount; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
      change_q <= |(stable_d ^ stable_q);
      for (int i = 0; i < GpioCount; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpio_o   = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed scenarios plus random pad activity,
// checked against a sliding-window model of the acceptance rule.
module tb_gpio_in_debounce;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] gpio_raw = '0;
  logic         bypass = 1'b0;
  logic [N-1:0] gpio_o;
  logic [N-1:0] rise_o;
  logic [N-1:0] fall_o;
  logic         change_o;

  int compared = 0;
  int mismatched = 0;

  // Model state: two-deep synchroniser, accepted level, expected pulses, and
  // the last D pre-edge synchronised samples with their bypass flags.
  logic [N-1:0] m_s0, m_s1, m_stable, m_rise, m_fall;
  logic         m_change;
  logic [N-1:0] hs_q[$];
  bit           hb_q[$];

  gpio_in_debounce #(
    .GpioCount(N), .SyncStages(2), .DebounceCycles(D), .ResetValue(4'b0000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .gpio_raw_i(gpio_raw), .bypass_i(bypass),
    .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o), .change_o(change_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_stable = '0;
    m_rise = '0; m_fall = '0; m_change = 1'b0;
    hs_q.delete();
    hb_q.delete();
  endtask

  // A bit flips when the last D samples were all taken outside bypass and
  // all disagree with the accepted level; in bypass it simply follows.
  task automatic model_edge();
    logic [N-1:0] s, ns, h;
    bit all_diff;
    s = m_s1;
    hs_q.push_back(s);
    hb_q.push_back(bypass);
    if (hs_q.size() > D) begin
      void'(hs_q.pop_front());
      void'(hb_q.pop_front());
    end
    ns = m_stable;
    for (int i = 0; i < N; i++) begin
      if (bypass) begin
        ns[i] = s[i];
      end else if (hs_q.size() == D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
          h = hs_q[k];
          if (hb_q[k] || (h[i] == m_stable[i])) all_diff = 1'b0;
        end
        if (all_diff) ns[i] = ~m_stable[i];
      end
    end
    m_rise   = ns & ~m_stable;
    m_fall   = ~ns & m_stable;
    m_change = |(ns ^ m_stable);
    m_stable = ns;
    m_s1     = m_s0;
    m_s0     = gpio_raw;
  endtask

  task automatic check_all();
    check("gpio_o", gpio_o, m_stable);
    check("rise_o", rise_o, m_rise);
    check("fall_o", fall_o, m_fall);
    check("change_o", {3'b000, change_o}, {3'b000, m_change});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_ni) model_edge();
    #1;
    check_all();
  endtask

  task automatic assert_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  int r1, p2;

  initial begin
    model_reset();

    // Reset with all pads high: nothing leaks out until normal acceptance.
    gpio_raw = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_hold_gpio", gpio_o, 4'h0);
    end
    rst_ni = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("rst_rel_gpio_e5", gpio_o, 4'h0);
    end
    check("rst_rel_gpio_e6", gpio_o, 4'hF);
    check("rst_rel_rise_e6", rise_o, 4'hF);
    check("rst_rel_chg_e6", {3'b000, change_o}, 4'h1);
    step();
    check("rst_rel_rise_e7", rise_o, 4'h0);

    gpio_raw = 4'h0;
    for (int k = 0; k < 8; k++) step();
    check("all_low", gpio_o, 4'h0);

    // Clean step on bit 0, both directions.
    gpio_raw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) check("clean_rise_e5", gpio_o, 4'h0);
      if (k == 6) check("clean_rise_e6", rise_o, 4'h1);
      if (k == 7) check("clean_rise_e7", rise_o, 4'h0);
    end
    gpio_raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("clean_fall_e5", gpio_o, 4'h1);
    end
    check("clean_fall_e6", fall_o, 4'h1);

    // Bounce on bit 1: one value per cycle, then held high.
    begin
      logic [9:0] pat;
      pat = 10'b1111101101;
      r1 = 0;
      for (int k = 0; k < 18; k++) begin
        gpio_raw[1] = (k < 10) ? pat[k] : 1'b1;
        step();
        if (rise_o[1]) r1++;
      end
      check("bounce_rise_count", 4'(r1), 4'd1);
      check("bounce_level", {3'b000, gpio_o[1]}, 4'h1);
    end

    // Three-cycle glitch on bit 2 must be rejected.
    p2 = 0;
    for (int k = 0; k < 12; k++) begin
      gpio_raw[2] = (k < 3);
      step();
      if (rise_o[2] || fall_o[2]) p2++;
    end
    check("glitch_pulses", 4'(p2), 4'd0);
    check("glitch_level", {3'b000, gpio_o[2]}, 4'h0);

    // Bypass: three-edge latency, then toggles, then debounce restored.
    bypass = 1'b1;
    gpio_raw[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) check("byp_lat_e2", {3'b000, gpio_o[3]}, 4'h0);
    end
    check("byp_lat_e3", {3'b000, gpio_o[3]}, 4'h1);
    check("byp_rise_e3", rise_o, 4'h8);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) gpio_raw[3] = ~gpio_raw[3];
      step();
    end
    bypass = 1'b0;
    gpio_raw[3] = ~gpio_raw[3];
    for (int k = 0; k < 10; k++) step();

    // Reset while bit 0 is mid-count (count reaches 2 after edge 4).
    gpio_raw = 4'h0;
    for (int k = 0; k < 8; k++) step();
    gpio_raw[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    assert_reset();
    check("midrst_gpio", gpio_o, 4'h0);
    step();
    step();
    rst_ni = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("midrst_e5", gpio_o, 4'h0);
    end
    check("midrst_e6", gpio_o, 4'h1);
    check("midrst_rise_e6", rise_o, 4'h1);

    // Random pad activity with occasional bypass toggles and resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) gpio_raw[i] = ~gpio_raw[i];
      end
      if ($urandom_range(0, 59) == 0) bypass = ~bypass;
      if (!rst_ni) rst_ni = 1'b1;
      else if ($urandom_range(0, 299) == 0) assert_reset();
      step();
    end
    rst_ni = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
